// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Resolves ID-stage control flow (J, JAL, BEQ, BNE, JR) and issues a
//   registered one-cycle redirect to the fetch stage.
//
//   If the fetch stage is stalled, the redirect is held in a single
//   pending slot and issued once the stall clears.
//
//   Optional build macro:
//     DELAY_SLOT_EN  Selects branch-delay-slot semantics.
//                    When defined: flush stays 0 and the JAL link
//                    address is PC+8.
//                    When undefined: flush pulses with every redirect
//                    and the link address is PC+4.
//
//   Ports:
//     clk, rst_n        clock; synchronous active-low reset
//     inst, inst_valid  ID-stage instruction word and its valid flag
//     pc_plus4          PC of inst plus 4
//     rs_val, rt_val    forwarded register operands
//     stall             IF stage cannot accept a redirect this cycle
//     pc_src            one-cycle redirect strobe
//     jmp_addr          redirect target; holds its value between strobes
//     flush             kill the instruction fetched after the branch
//     link_we           $31 write request, coincident with a JAL redirect
//     link_addr         $31 write data
//     taken_cnt         saturating count of issued redirects
module branch_resolve_unit #(
    parameter int AW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst,
    input  logic             inst_valid,
    input  logic [AW-1:0]    pc_plus4,
    input  logic [AW-1:0]    rs_val,
    input  logic [AW-1:0]    rt_val,
    input  logic             stall,
    output logic             pc_src,
    output logic [AW-1:0]    jmp_addr,
    output logic             flush,
    output logic             link_we,
    output logic [AW-1:0]    link_addr,
    output logic [CNT_W-1:0] taken_cnt
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] PEND = 1'b1;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] FN_JR      = 6'h08;

    logic [0:0]    state, state_next;
    logic [5:0]    opcode, funct;
    logic          is_j, is_jal, is_beq, is_bne, is_jr;
    logic          taken;
    logic [AW-1:0] branch_offset, jump_target, branch_target, target, link_value;

    logic [AW-1:0] pend_target, pend_link;
    logic          pend_jal;

    logic          issue, issue_jal, capture;
    logic [AW-1:0] issue_target, issue_link;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];

    assign is_j   = (opcode == OP_J);
    assign is_jal = (opcode == OP_JAL);
    assign is_beq = (opcode == OP_BEQ);
    assign is_bne = (opcode == OP_BNE);
    assign is_jr  = (opcode == OP_SPECIAL) && (funct == FN_JR);

    // Sign-extended word offset; the add wraps naturally at AW bits.
    assign branch_offset = {{(AW-18){inst[15]}}, inst[15:0], 2'b00};
    assign branch_target = pc_plus4 + branch_offset;
    assign jump_target   = {pc_plus4[AW-1:28], inst[25:0], 2'b00};

`ifdef DELAY_SLOT_EN
    assign link_value = pc_plus4 + {{(AW-3){1'b0}}, 3'd4};
`else
    assign link_value = pc_plus4;
`endif

    always_comb begin
        target = jump_target;
        if (is_jr)
            target = rs_val;
        else if (is_beq || is_bne)
            target = branch_target;
    end

    assign taken = inst_valid &&
                   (is_j || is_jal || is_jr ||
                    (is_beq && (rs_val == rt_val)) ||
                    (is_bne && (rs_val != rt_val)));

    // Decide whether to issue a redirect this edge, and from which source.
    always_comb begin
        issue        = 1'b0;
        capture      = 1'b0;
        issue_target = pend_target;
        issue_jal    = pend_jal;
        issue_link   = pend_link;
        state_next   = state;
        case (state)
            IDLE: begin
                if (taken) begin
                    if (!stall) begin
                        issue        = 1'b1;
                        issue_target = target;
                        issue_jal    = is_jal;
                        issue_link   = link_value;
                    end else begin
                        capture    = 1'b1;
                        state_next = PEND;
                    end
                end
            end
            PEND: begin
                if (!stall) begin
                    issue      = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc_src      <= 1'b0;
            flush       <= 1'b0;
            link_we     <= 1'b0;
            jmp_addr    <= '0;
            link_addr   <= '0;
            taken_cnt   <= '0;
            pend_target <= '0;
            pend_link   <= '0;
            pend_jal    <= 1'b0;
        end else begin
            state   <= state_next;
            pc_src  <= issue;
            link_we <= issue && issue_jal;
`ifdef DELAY_SLOT_EN
            flush   <= 1'b0;
`else
            flush   <= issue;
`endif
            if (issue)
                jmp_addr <= issue_target;
            if (issue && issue_jal)
                link_addr <= issue_link;
            if (capture) begin
                pend_target <= target;
                pend_jal    <= is_jal;
                pend_link   <= link_value;
            end
            // The count trails the strobe by one cycle.
            if (pc_src && (taken_cnt != '1))
                taken_cnt <= taken_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule
